// File: rtl/cic_pkg.sv
// Shared sizing helpers for the CIC interpolator and its integrator stages.
package cic_pkg;

    function automatic int cic_out_width(input int in_w, input int n, input int r, input int m);
        return in_w + n * $clog2(r * m);
    endfunction

    // The phase counter needs at least one bit even when R is a power of two near the minimum.
    function automatic int cic_phase_width(input int r);
        return (r > 2) ? $clog2(r) : 1;
    endfunction

    localparam int DEF_R = 4;

    typedef logic [cic_phase_width(DEF_R)-1:0] cic_phase_t;

endpackage

// File: rtl/cic_integ.sv
// One enabled accumulator stage: y <= y + x whenever en is high; wraps modulo 2^WIDTH.
module cic_integ #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    assign acc_d = acc_q + x;
    assign y     = acc_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/cic_interpolator_vc.sv
// Assertion checker bound into every cic_interpolator: phase range and stall behaviour.
module cic_interpolator_vc #(
    parameter int R  = 4,
    parameter int PW = 2,
    parameter int OW = 14
) (
    input logic          clk,
    input logic          rstn,
    input logic [PW-1:0] phase_i,
    input logic          in_ready_i,
    input logic          out_valid_i,
    input logic          out_ready_i,
    input logic [OW-1:0] out_data_i
);

    a_phase_range: assert property (@(posedge clk) disable iff (!rstn)
        phase_i <= PW'(R - 1));

    a_stall_blocks_input: assert property (@(posedge clk) disable iff (!rstn)
        (out_valid_i && !out_ready_i) |-> !in_ready_i);

    a_stall_holds: assert property (@(posedge clk) disable iff (!rstn)
        (rstn && out_valid_i && !out_ready_i) |=> ($stable(out_data_i) && $stable(phase_i) && out_valid_i));

endmodule

bind cic_interpolator cic_interpolator_vc #(
    .R  (R),
    .PW (PW),
    .OW (OUT_WIDTH)
) u_vc (
    .clk         (clk),
    .rstn        (rstn),
    .phase_i     (phase_q),
    .in_ready_i  (in_ready),
    .out_valid_i (out_valid),
    .out_ready_i (out_ready),
    .out_data_i  (out_data)
);

// File: rtl/cic_interpolator.sv
// CIC interpolator: N comb stages at the input rate, zero-stuffing by R, N integrators at the output rate.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int  IN_WIDTH  = 8,
    parameter int  N_STAGES  = 3,
    parameter int  R         = 4,
    parameter int  M         = 1,
    localparam int OUT_WIDTH = cic_out_width(IN_WIDTH, N_STAGES, R, M)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PW = cic_phase_width(R);

    logic [PW-1:0]        phase_q;
    logic [PW-1:0]        phase_d;
    logic                 out_valid_q;
    logic                 adv;
    logic                 step;
    logic                 accept;
    logic [OUT_WIDTH-1:0] up_d;
    logic [OUT_WIDTH-1:0] comb_c [N_STAGES+1];
    logic [OUT_WIDTH-1:0] integ_y [N_STAGES];

    // Handshake: a beat moves when out_valid && out_ready; a sample moves when in_valid && in_ready.
    // The whole datapath advances only on step, so output backpressure freezes every register.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = rstn && adv && (phase_q == '0);
    assign step     = adv && ((phase_q != '0) || in_valid);
    assign accept   = step && (phase_q == '0);
    assign phase_d  = (phase_q == PW'(R - 1)) ? '0 : phase_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (step) begin
                phase_q <= phase_d;
            end
            if (step) begin
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign comb_c[0] = {{(OUT_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

    for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
        logic [OUT_WIDTH-1:0] dly_q [M];

        always_ff @(posedge clk) begin
            if (!rstn) begin
                for (int i = 0; i < M; i++) begin
                    dly_q[i] <= '0;
                end
            end else if (accept) begin
                dly_q[0] <= comb_c[k];
                for (int i = 1; i < M; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign comb_c[k+1] = comb_c[k] - dly_q[M-1];
    end

    assign up_d = (phase_q == '0) ? comb_c[N_STAGES] : '0;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_integ
        if (k == 0) begin : g_first
            cic_integ #(.WIDTH(OUT_WIDTH)) u_integ (
                .clk  (clk),
                .rstn (rstn),
                .en   (step),
                .x    (up_d),
                .y    (integ_y[k])
            );
        end else begin : g_rest
            cic_integ #(.WIDTH(OUT_WIDTH)) u_integ (
                .clk  (clk),
                .rstn (rstn),
                .en   (step),
                .x    (integ_y[k-1]),
                .y    (integ_y[k])
            );
        end
    end

    assign out_data  = integ_y[N_STAGES-1];
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator at default parameters; expected beats come from convolution with the impulse response.
module tb_cic_interpolator;

  localparam int IW = 8;
  localparam int OW = 14;
  localparam int RR = 4;
  localparam int HL = 10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [OW-1:0] exp_q[$];
  int            hist[$];
  int            h [HL] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
  bit            bp_en = 1'b0;
  logic [OW-1:0] last_out = '0;

  cic_interpolator dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  // random downstream readiness while bp_en is set
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // beat n (counted from reset) = sum_k x[k] * h[n - 2 - R*k], modulo 2^OW
  function automatic logic [OW-1:0] model_beat(input int n);
    int e;
    int k0;
    int t;
    e = 0;
    k0 = (n / RR) - 3;
    if (k0 < 0) k0 = 0;
    for (int k = k0; k < hist.size(); k++) begin
      t = n - 2 - RR * k;
      if (t >= 0 && t < HL) e += hist[k] * h[t];
    end
    return OW'(e);
  endfunction

  // scoreboard: push on accepted sample, pop on consumed beat
  always @(negedge clk) begin
    logic [OW-1:0] e;
    int j;
    if (!rstn) begin
      hist.delete();
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        hist.push_back(int'($signed(in_data)));
        j = hist.size() - 1;
        for (int p = 0; p < RR; p++) exp_q.push_back(model_beat(RR * j + p));
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %b want 0 at %0t", in_ready, $time);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %0d with empty queue at %0t", $signed(out_data), $time);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL beat: got %0d want %0d at %0t", $signed(out_data), $signed(e), $time);
          end
        end
        last_out = out_data;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [IW-1:0] v);
    int cnt;
    cnt = 0;
    in_data = v;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      cnt++;
      if (cnt > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: sample %0d not accepted in 200 cycles", $signed(v));
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d beats pending want 0", name, exp_q.size());
    end
  endtask

  // tests
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", $signed(out_data)); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_impulse(input string name);
    send(8'sd1);
    for (int i = 0; i < 15; i++) send('0);
    idle(8);
    check_drained(name);
    checks++;
    if (last_out !== '0) begin errors++; $display("FAIL %s_tail: got %0d want 0", name, $signed(last_out)); end
  endtask

  task automatic test_dc();
    for (int i = 0; i < 40; i++) send(8'sd1);
    checks++;
    if (last_out !== OW'(16)) begin errors++; $display("FAIL dc_plus1: got %0d want 16", $signed(last_out)); end
    for (int i = 0; i < 40; i++) send(8'h80);
    checks++;
    if (last_out !== OW'(-2048)) begin errors++; $display("FAIL dc_min: got %0d want -2048", $signed(last_out)); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 2000; i++) send(8'h80);
    checks++;
    if (last_out !== OW'(-2048)) begin errors++; $display("FAIL wrap_dc: got %0d want -2048", $signed(last_out)); end
    idle(8);
    check_drained("wrap");
  endtask

  task automatic test_backpressure();
    bp_en = 1'b1;
    for (int i = 0; i < 80; i++) send(IW'($urandom_range(0, 255)));
    bp_en = 1'b0;
    idle(20);
    check_drained("backpressure");
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 6; i++) send(IW'($urandom_range(0, 255)));
    idle(8);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL underflow_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL underflow_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 8; i++) send(IW'($urandom_range(0, 255)));
    idle(8);
    check_drained("underflow");
  endtask

  task automatic test_reset_mid();
    send(8'sd5);
    in_data = 8'sd7;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL midreset_out_data: got %0d want 0", $signed(out_data)); end
    @(posedge clk);
    #1;
    test_impulse("impulse_after_reset");
  endtask

  initial begin
    test_reset();
    test_impulse("impulse");
    test_dc();
    test_wrap();
    test_backpressure();
    test_underflow();
    test_reset_mid();
    idle(10);
    check_drained("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
